truth_table_scanner: RTL and testbench

- Sequential counterpart to our combinational mux-tree function blocks.
- Drives every input combination of an N-variable Boolean function, samples the function output, and reconstructs the truth table, minterm list and minterm count.
- Used as an on-chip checker and characteriser: vars_out feeds {A,B,C,D} of the function under test, and f_in returns its Y.

---
 rtl/truth_table_scanner.sv | 133 +++++++++++++
 tb/tb_truth_table_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks every input combination of an N-variable function,
// samples its output and rebuilds the truth table, minterm count and ordered minterm stream.
module truth_table_scanner #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_VARS-1:0]    vars_out,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_VARS-1:0] truth_table,
  output logic [N_VARS:0]      minterm_count,
  output logic                 mt_valid,
  output logic [N_VARS-1:0]    mt_index,
  input  logic                 mt_ready
);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;

  localparam logic [N_VARS-1:0] LAST_IDX    = {N_VARS{1'b1}};
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

  state_t                 state_q, state_d;
  logic [N_VARS-1:0]      idx_q, idx_d;
  logic [3:0]             settle_q, settle_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [2**N_VARS-1:0]   truth_table_q, truth_table_d;
  logic [N_VARS:0]        minterm_count_q, minterm_count_d;
  logic                   mt_valid_q, mt_valid_d;
  logic [N_VARS-1:0]      mt_index_q, mt_index_d;
  logic                   advance;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    settle_d        = settle_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    truth_table_d   = truth_table_q;
    minterm_count_d = minterm_count_q;
    mt_valid_d      = mt_valid_q;
    mt_index_d      = mt_index_q;
    advance         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d         = DRIVE;
          idx_d           = '0;
          settle_d        = '0;
          truth_table_d   = '0;
          minterm_count_d = '0;
          busy_d          = 1'b1;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          truth_table_d[idx_q] = f_in;
          if (f_in) begin
            minterm_count_d = minterm_count_q + (N_VARS+1)'(1);
            mt_valid_d      = 1'b1;
            mt_index_d      = idx_q;
            state_d         = EMIT;
          end else begin
            advance = 1'b1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      EMIT: begin
        if (mt_ready) begin
          mt_valid_d = 1'b0;
          advance    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared step out of DRIVE (zero result) or EMIT (handshake complete).
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        idx_d    = idx_q + N_VARS'(1);
        settle_d = '0;
        state_d  = DRIVE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      settle_q        <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      truth_table_q   <= '0;
      minterm_count_q <= '0;
      mt_valid_q      <= 1'b0;
      mt_index_q      <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      settle_q        <= settle_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      truth_table_q   <= truth_table_d;
      minterm_count_q <= minterm_count_d;
      mt_valid_q      <= mt_valid_d;
      mt_index_q      <= mt_index_d;
    end
  end

  assign vars_out      = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign truth_table   = truth_table_q;
  assign minterm_count = minterm_count_q;
  assign mt_valid      = mt_valid_q;
  assign mt_index      = mt_index_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - self-checking bench for truth_table_scanner.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, f_in, mt_ready;
  logic [3:0]  vars_out, mt_index;
  logic        busy, done, mt_valid;
  logic [15:0] truth_table;
  logic [4:0]  minterm_count;
  logic [15:0] func;

  logic        start3, f3, mt_ready3, busy3, done3, mt_valid3;
  logic [3:0]  vars3, mt_index3, d1, d2;
  logic [15:0] tt3;
  logic [4:0]  mc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign f_in = func[vars_out];

  always @(posedge clk) begin
    d1 <= vars3;
    d2 <= d1;
  end
  assign f3 = d2[3] ^ d2[0];

  truth_table_scanner #(.N_VARS(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .vars_out(vars_out), .f_in(f_in),
    .busy(busy), .done(done), .truth_table(truth_table), .minterm_count(minterm_count),
    .mt_valid(mt_valid), .mt_index(mt_index), .mt_ready(mt_ready)
  );

  truth_table_scanner #(.N_VARS(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .vars_out(vars3), .f_in(f3),
    .busy(busy3), .done(done3), .truth_table(tt3), .minterm_count(mc3),
    .mt_valid(mt_valid3), .mt_index(mt_index3), .mt_ready(mt_ready3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts a scan of fn and follows it to done; mode 0 = ready always high,
  // 1 = random ready, 2 = five stall cycles per minterm. Checks against the model.
  task automatic run_scan(input string tag, input logic [15:0] fn, input int mode,
                          input bit poke_start, output int edges, output int stalls);
    int exp_q[$];
    int got_q[$];
    int scnt;
    bit prev_stall;
    logic [3:0] prev_idx;
    bit finished;
    func = fn;
    mt_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    edges = 0; stalls = 0; scnt = 0; prev_stall = 0; prev_idx = '0; finished = 0;
    for (int k = 0; k < 3000 && !finished; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (prev_stall)
        check({tag, ".stall_hold"}, {27'd0, mt_valid, mt_index}, {27'd0, 1'b1, prev_idx});
      if (done) begin
        finished = 1;
        check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
      end else begin
        start = (poke_start && edges == 5);
        case (mode)
          0: mt_ready = 1'b1;
          1: mt_ready = 1'($urandom_range(0, 1));
          default: begin
            if (mt_valid && scnt < 5) begin
              mt_ready = 1'b0;
              scnt++;
            end else begin
              mt_ready = 1'b1;
              if (mt_valid) scnt = 0;
            end
          end
        endcase
        prev_stall = mt_valid && !mt_ready;
        prev_idx = mt_index;
        if (prev_stall) stalls++;
        if (mt_valid && mt_ready) got_q.push_back(int'(mt_index));
      end
    end
    start = 1'b0;
    mt_ready = 1'b1;
    if (!finished) check({tag, ".timeout"}, 32'd0, 32'd1);
    for (int i = 0; i < 16; i++) if (fn[i]) exp_q.push_back(i);
    check({tag, ".emit_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.emit%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, ".tt"}, 32'(truth_table), 32'(fn));
    check({tag, ".count"}, 32'(minterm_count), 32'($countones(fn)));
    check({tag, ".latency"}, 32'(edges), 32'(16 + $countones(fn) + stalls));
  endtask

  typedef struct {
    logic [15:0] fn;
    int          mode;
    logic [15:0] exp_tt;
    int          exp_cnt;
    int          exp_edges;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int edges, stalls;
    logic [15:0] gold3;
    bit ok;

    vecs[0] = '{16'h3C5A, 0, 16'h3C5A, 8, 24};
    vecs[1] = '{16'h3C5A, 2, 16'h3C5A, 8, 64};
    vecs[2] = '{16'h0000, 0, 16'h0000, 0, 16};
    vecs[3] = '{16'hFFFF, 0, 16'hFFFF, 16, 32};
    vecs[4] = '{16'h8001, 0, 16'h8001, 2, 18};
    vecs[5] = '{16'hFFFF, 2, 16'hFFFF, 16, 112};

    rst = 1'b0; start = 1'b0; mt_ready = 1'b1; func = '0;
    start3 = 1'b0; mt_ready3 = 1'b1;
    #2 rst = 1'b1;
    #2;
    check("reset.outputs", {7'd0, vars_out, busy, done, truth_table},  32'd0);
    check("reset.mt", {22'd0, minterm_count, mt_valid, mt_index}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      run_scan($sformatf("vec%0d", i), vecs[i].fn, vecs[i].mode, 1'b0, edges, stalls);
      check($sformatf("vec%0d.tt_table", i), 32'(truth_table), 32'(vecs[i].exp_tt));
      check($sformatf("vec%0d.cnt_table", i), 32'(minterm_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d.edges_table", i), 32'(edges), 32'(vecs[i].exp_edges));
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d.hold", i), 32'(truth_table), 32'(vecs[i].exp_tt));
    end

    for (int r = 0; r < 6; r++) begin
      run_scan($sformatf("rand%0d", r), 16'($urandom), 1, 1'b0, edges, stalls);
      @(negedge clk);
    end

    // Start poked mid-scan, then pulsed during DONE: neither restarts.
    run_scan("poke", 16'h3C5A, 0, 1'b1, edges, stalls);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_pulse.busy", 32'(busy), 32'd0);
    check("done_pulse.tt", 32'(truth_table), 32'h3C5A);

    // Start held across DONE begins a new scan on the first IDLE edge.
    run_scan("held", 16'h00FF, 0, 1'b0, edges, stalls);
    start = 1'b1;
    @(negedge clk);
    check("held.idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("held.restart_busy", 32'(busy), 32'd1);
    check("held.cleared_tt", 32'(truth_table), 32'd0);
    start = 1'b0;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    check("held.done_seen", 32'(ok), 32'd1);
    check("held.tt", 32'(truth_table), 32'h00FF);
    check("held.count", 32'(minterm_count), 32'd8);

    // Async reset while stalled in EMIT at index 6.
    func = 16'h3C5A;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      mt_ready = !(mt_valid && mt_index == 4'd6);
      if (mt_valid && mt_index == 4'd6) ok = 1;
    end
    check("rst_emit.reached6", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_emit.stalled", {27'd0, mt_valid, mt_index}, 32'h16);
    #2 rst = 1'b1;
    #1;
    check("rst_emit.outputs", {7'd0, vars_out, busy, done, truth_table}, 32'd0);
    check("rst_emit.mt", {22'd0, minterm_count, mt_valid, mt_index}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mt_ready = 1'b1;
    run_scan("after_rst", 16'h0F0F, 0, 1'b0, edges, stalls);
    check("after_rst.edges", 32'(edges), 32'd24);

    // SETTLE=3 instance fed through a two-register delayed Y = A ^ D.
    for (int i = 0; i < 16; i++) gold3[i] = ((i >> 3) & 1) != (i & 1);
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    edges = 0;
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done3) ok = 1;
    end
    check("settle3.done_seen", 32'(ok), 32'd1);
    check("settle3.tt", 32'(tt3), 32'(gold3));
    check("settle3.count", 32'(mc3), 32'($countones(gold3)));
    check("settle3.edges", 32'(edges), 32'(48 + $countones(gold3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
